// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - capture controller gating LPC records into the ring buffer
//
// Purpose:
//   Filters decoded LPC records by cycle type and address window and forwards
//   accepted records to the ring buffer. While the buffer is full, matched
//   records are dropped and counted; once space returns a single drop-marker
//   record is written ahead of normal traffic so the host can see each gap.
//
// Ports:
//   clock          in   ext_clock, all logic on its rising edge
//   reset          in   asynchronous, active-high
//   in_data        in   record from bufferdomain {addr, data, tag, cyctype_dir}
//   in_enable      in   1-cycle record strobe (>=4 cycles apart)
//   buf_full       in   ring buffer cannot accept a write this cycle
//   arm            in   level, 1 = capture enabled
//   cyc_mask       in   bit i accepts records whose cyctype_dir == i
//   addr_lo        in   inclusive lower address bound
//   addr_hi        in   inclusive upper address bound
//   out_data       out  record to ring buffer write_data
//   out_enable     out  1-cycle ring buffer write strobe
//   capturing      out  high whenever the controller is armed
//   dropped_total  out  saturating drop count since the last arm rise

module capture_ctrl #(
  parameter int          DW         = 48,
  parameter int          CW         = 16,
  parameter logic [3:0]  MARKER_TAG = 4'hF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_enable,
  input  logic          buf_full,
  input  logic          arm,
  input  logic [15:0]   cyc_mask,
  input  logic [31:0]   addr_lo,
  input  logic [31:0]   addr_hi,
  output logic [DW-1:0] out_data,
  output logic          out_enable,
  output logic          capturing,
  output logic [CW-1:0] dropped_total
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    CAPTURE  = 2'd1,
    DROPPING = 2'd2,
    MARKER   = 2'd3
  } state_t;

  state_t        state_q;
  logic [DW-1:0] out_data_q;
  logic          out_enable_q;
  logic          capturing_q;
  logic [CW-1:0] dropped_q;
  logic [CW-1:0] episode_q;
  logic [DW-1:0] hold_q;

  logic [CW-1:0] dropped_d;
  logic [CW-1:0] episode_d;
  logic [DW-1:0] marker_d;
  logic [31:0]   rec_addr;
  logic [3:0]    rec_type;
  logic          in_window;
  logic          match;

  // Record filter. An inverted window (lo > hi) can never satisfy both
  // comparisons, so it naturally matches nothing.
  assign rec_addr  = in_data[47:16];
  assign rec_type  = in_data[3:0];
  assign in_window = (rec_addr >= addr_lo) && (rec_addr <= addr_hi);
  assign match     = in_enable && cyc_mask[rec_type] && in_window;

  // Saturating increments: both counters stick at all-ones.
  assign dropped_d = (dropped_q == {CW{1'b1}}) ? dropped_q : dropped_q + CW'(1);
  assign episode_d = (episode_q == {CW{1'b1}}) ? episode_q : episode_q + CW'(1);

  // Marker record reports how many records were lost in this episode.
  assign marker_d = {32'(episode_q), 8'hFF, MARKER_TAG, 4'hF};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= DISARMED;
      out_data_q   <= '0;
      out_enable_q <= 1'b0;
      capturing_q  <= 1'b0;
      dropped_q    <= '0;
      episode_q    <= '0;
      hold_q       <= '0;
    end else begin
      // Write strobe is a single-cycle pulse unless a branch below issues one.
      out_enable_q <= 1'b0;

      if (!arm) begin
        // Disarm wins from any state; pending marker and held record are
        // abandoned, but the drop total stays visible until the next arm.
        state_q     <= DISARMED;
        capturing_q <= 1'b0;
      end else begin
        unique case (state_q)
          DISARMED: begin
            dropped_q   <= '0;
            episode_q   <= '0;
            state_q     <= CAPTURE;
            capturing_q <= 1'b1;
          end

          CAPTURE: begin
            if (match) begin
              if (!buf_full) begin
                out_data_q   <= in_data;
                out_enable_q <= 1'b1;
              end else begin
                dropped_q <= dropped_d;
                episode_q <= episode_d;
                state_q   <= DROPPING;
              end
            end
          end

          DROPPING: begin
            if (buf_full) begin
              if (match) begin
                dropped_q <= dropped_d;
                episode_q <= episode_d;
              end
            end else begin
              // Space is back: the marker always goes first. A record that
              // arrives in this same cycle is parked and follows next cycle.
              out_data_q   <= marker_d;
              out_enable_q <= 1'b1;
              episode_q    <= '0;
              if (match) begin
                hold_q  <= in_data;
                state_q <= MARKER;
              end else begin
                state_q <= CAPTURE;
              end
            end
          end

          MARKER: begin
            // Held record waits here until the buffer can take it; strobe
            // spacing upstream guarantees no new record arrives meanwhile.
            if (!buf_full) begin
              out_data_q   <= hold_q;
              out_enable_q <= 1'b1;
              state_q      <= CAPTURE;
            end
          end

          default: state_q <= DISARMED;
        endcase
      end
    end
  end

  assign out_data      = out_data_q;
  assign out_enable    = out_enable_q;
  assign capturing     = capturing_q;
  assign dropped_total = dropped_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - self-checking bench for capture_ctrl
module tb_capture_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] in_data;
  logic        in_enable;
  logic        buf_full;
  logic        arm;
  logic [15:0] cyc_mask;
  logic [31:0] addr_lo;
  logic [31:0] addr_hi;

  logic [47:0] out_data;
  logic        out_enable;
  logic        capturing;
  logic [15:0] dropped_total;

  logic [47:0] out_data4;
  logic        out_enable4;
  logic        capturing4;
  logic [3:0]  dropped_total4;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  capture_ctrl #(.DW(48), .CW(16), .MARKER_TAG(4'hF)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_enable(in_enable),
    .buf_full(buf_full), .arm(arm), .cyc_mask(cyc_mask), .addr_lo(addr_lo),
    .addr_hi(addr_hi), .out_data(out_data), .out_enable(out_enable),
    .capturing(capturing), .dropped_total(dropped_total)
  );

  capture_ctrl #(.DW(48), .CW(4), .MARKER_TAG(4'hF)) dut4 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_enable(in_enable),
    .buf_full(buf_full), .arm(arm), .cyc_mask(cyc_mask), .addr_lo(addr_lo),
    .addr_hi(addr_hi), .out_data(out_data4), .out_enable(out_enable4),
    .capturing(capturing4), .dropped_total(dropped_total4)
  );

  typedef struct {
    logic        arm;
    logic        en;
    logic [47:0] data;
    logic        full;
    logic [15:0] mask;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        x_oe;
    logic [47:0] x_data;
    logic        x_cap;
    logic [15:0] x_drop;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] cur_mask = 16'hFFFF;
  logic [31:0] cur_lo   = 32'h0;
  logic [31:0] cur_hi   = 32'hFFFF_FFFF;

  task automatic add(input logic a, input logic en, input logic [47:0] d,
                     input logic full, input logic xoe, input logic [47:0] xd,
                     input logic xcap, input logic [15:0] xdrop);
    vec_t v;
    v.arm = a; v.en = en; v.data = d; v.full = full;
    v.mask = cur_mask; v.lo = cur_lo; v.hi = cur_hi;
    v.x_oe = xoe; v.x_data = xd; v.x_cap = xcap; v.x_drop = xdrop;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input logic full, input logic [15:0] xdrop);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, 48'h0, full, 1'b0, 48'h0, 1'b1, xdrop);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; in_enable = 1'b0; in_data = '0; buf_full = 1'b0;
    cyc_mask = 16'hFFFF; addr_lo = 32'h0; addr_hi = 32'hFFFF_FFFF;

    // Basic pass-through
    add(1, 0, 48'h0, 0, 0, 48'h0, 1, 0);
    add(1, 1, 48'h0000_0080_AB02, 0, 1, 48'h0000_0080_AB02, 1, 0);
    idle(3, 0, 0);

    // Cycle-type mask
    cur_mask = 16'h0004;
    add(1, 1, 48'h0000_0080_AB02, 0, 1, 48'h0000_0080_AB02, 1, 0);
    idle(3, 0, 0);
    add(1, 1, 48'h0000_0080_AB00, 0, 0, 48'h0, 1, 0);
    idle(3, 0, 0);

    // Address window, inclusive edges, inverted window
    cur_mask = 16'hFFFF; cur_lo = 32'h80; cur_hi = 32'h80;
    add(1, 1, 48'h0000_0081_1200, 0, 0, 48'h0, 1, 0);
    idle(3, 0, 0);
    add(1, 1, 48'h0000_0080_1203, 0, 1, 48'h0000_0080_1203, 1, 0);
    idle(3, 0, 0);
    cur_lo = 32'h81;
    add(1, 1, 48'h0000_0080_1203, 0, 0, 48'h0, 1, 0);
    idle(3, 0, 0);
    cur_lo = 32'h0; cur_hi = 32'hFFFF_FFFF;

    // Three drops, then marker and normal traffic
    add(1, 1, 48'h0000_1000_0101, 1, 0, 48'h0, 1, 1);
    idle(3, 1, 1);
    add(1, 1, 48'h0000_1001_0201, 1, 0, 48'h0, 1, 2);
    idle(3, 1, 2);
    add(1, 1, 48'h0000_1002_0301, 1, 0, 48'h0, 1, 3);
    idle(3, 1, 3);
    add(1, 0, 48'h0, 0, 1, 48'h0000_0003_FFFF, 1, 3);
    idle(3, 0, 3);
    add(1, 1, 48'h0000_2000_4404, 0, 1, 48'h0000_2000_4404, 1, 3);
    idle(3, 0, 3);

    // Release coincides with a matched strobe: marker then held record
    add(1, 1, 48'h0000_3000_5505, 1, 0, 48'h0, 1, 4);
    idle(3, 1, 4);
    add(1, 1, 48'h0000_3001_6606, 0, 1, 48'h0000_0001_FFFF, 1, 4);
    add(1, 0, 48'h0, 0, 1, 48'h0000_3001_6606, 1, 4);
    idle(3, 0, 4);

    // Held record stalls while buffer refills
    add(1, 1, 48'h0000_4000_7707, 1, 0, 48'h0, 1, 5);
    idle(3, 1, 5);
    add(1, 1, 48'h0000_4001_8808, 0, 1, 48'h0000_0001_FFFF, 1, 5);
    add(1, 0, 48'h0, 1, 0, 48'h0, 1, 5);
    add(1, 0, 48'h0, 0, 1, 48'h0000_4001_8808, 1, 5);
    idle(3, 0, 5);

    // Disarm while dropping: no marker, total retained then cleared on re-arm
    add(1, 1, 48'h0000_5000_9909, 1, 0, 48'h0, 1, 6);
    idle(2, 1, 6);
    add(0, 0, 48'h0, 0, 0, 48'h0, 0, 6);
    add(0, 0, 48'h0, 0, 0, 48'h0, 0, 6);
    add(1, 0, 48'h0, 0, 0, 48'h0, 1, 0);
    idle(3, 0, 0);
    add(1, 1, 48'h0000_6000_AA0A, 0, 1, 48'h0000_6000_AA0A, 1, 0);
    idle(3, 0, 0);

    // Reset values
    step();
    step();
    chk("rst_out_enable", 64'(out_enable), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_capturing", 64'(capturing), 64'h0);
    chk("rst_dropped", 64'(dropped_total), 64'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      arm = vecs[i].arm; in_enable = vecs[i].en; in_data = vecs[i].data;
      buf_full = vecs[i].full; cyc_mask = vecs[i].mask;
      addr_lo = vecs[i].lo; addr_hi = vecs[i].hi;
      step();
      chk($sformatf("v%0d_out_enable", i), 64'(out_enable), 64'(vecs[i].x_oe));
      if (vecs[i].x_oe) chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].x_data));
      chk($sformatf("v%0d_capturing", i), 64'(capturing), 64'(vecs[i].x_cap));
      chk($sformatf("v%0d_dropped", i), 64'(dropped_total), 64'(vecs[i].x_drop));
    end

    // Asynchronous reset mid-capture, checked before the next clock edge
    in_enable = 1'b1; in_data = 48'h0000_7000_BB0B; buf_full = 1'b1;
    step();
    in_enable = 1'b0;
    repeat (3) step();
    buf_full = 1'b0;
    step();
    chk("pre_rst_marker_oe", 64'(out_enable), 64'h1);
    chk("pre_rst_dropped", 64'(dropped_total), 64'h1);
    reset = 1'b1;
    #1;
    chk("async_out_enable", 64'(out_enable), 64'h0);
    chk("async_out_data", 64'(out_data), 64'h0);
    chk("async_capturing", 64'(capturing), 64'h0);
    chk("async_dropped", 64'(dropped_total), 64'h0);

    // Saturation: 20 drops into a 4-bit counter
    step();
    reset = 1'b0; arm = 1'b1; buf_full = 1'b1;
    cyc_mask = 16'hFFFF; addr_lo = 32'h0; addr_hi = 32'hFFFF_FFFF;
    step();
    for (int k = 0; k < 20; k++) begin
      in_enable = 1'b1; in_data = 48'h0000_0100_5501;
      step();
      in_enable = 1'b0;
      repeat (3) step();
    end
    chk("sat_dropped_cw4", 64'(dropped_total4), 64'hF);
    chk("sat_dropped_cw16", 64'(dropped_total), 64'd20);
    buf_full = 1'b0;
    step();
    chk("sat_marker_oe_cw4", 64'(out_enable4), 64'h1);
    chk("sat_marker_cw4", 64'(out_data4), 64'h0000_000F_FFFF);
    chk("sat_marker_oe_cw16", 64'(out_enable), 64'h1);
    chk("sat_marker_cw16", 64'(out_data), 64'h0000_0014_FFFF);
    step();
    chk("sat_after_oe_cw4", 64'(out_enable4), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
